timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//   Memory-mapped 32-bit down-counting timer with interrupt, placed behind the
//   system bridge as TC0 (window 0x7F00-0x7F0B) and TC1 (0x7F10-0x7F1B).
//   The bridge drives Addr, WE and Din and muxes Dout back to the CPU.
//   IRQ goes to the CP0 hardware-interrupt inputs.
//   Three word registers: CTRL (+0x0), PRESET (+0x4), COUNT (+0x8, read-only).
// PARAMETERS
//   CTRL_MASK   32'h0000_000F  writable CTRL bits; all other bits read 0
//   RESET_CTRL  32'h0000_0000  CTRL value after reset
// PORTS
//   clk      in   1   system clock, rising edge
//   reset_n  in   1   asynchronous, active-low reset
//   Addr     in   32  byte address; only Addr[3:2] decoded (0=CTRL,1=PRESET,2=COUNT,3=none)
//   WE       in   1   write strobe, already qualified by the bridge's address range
//   Din      in   32  write data
//   Dout     out  32  read data for Addr[3:2]; 0 when Addr[3:2]==3
//   IRQ      out  1   interrupt request = CTRL.IM & irq_flag
// BEHAVIOUR
//   CTRL fields:
//     [0] EN   count enable
//     [2:1] MODE  00 = one-shot, 01 = auto-reload, 1x behaves as 00
//     [3] IM   interrupt mask (1 = IRQ enabled)
//   Reset (reset_n low, asynchronous):
//     CTRL = RESET_CTRL, PRESET = 0, COUNT = 0, irq_flag = 0, state = IDLE.
//     Therefore IRQ = 0 and Dout = 0 for all addresses.
//   Reads: combinational from register state, zero latency. Writes take effect
//     at the clock edge. Writes to COUNT or to offset 0xC are ignored.
//   CTRL writes store Din & CTRL_MASK. PRESET writes store Din in full.
//   FSM (registered state): IDLE -> LOAD -> CNT -> INT.
//     IDLE: if EN -> LOAD. IDLE itself has no effect on irq_flag.
//     LOAD: COUNT <= PRESET, irq_flag <= 0; -> CNT.
//     CNT:  if !EN -> IDLE, COUNT holds.
//           else if COUNT > 1 -> COUNT <= COUNT-1.
//           else COUNT <= 0 -> INT.
//           Note that a COUNT of 0 or 1 both go to INT.
//     INT:  irq_flag <= 1.
//           MODE 00: CTRL.EN <= 0, then -> IDLE.
//           MODE 01: -> LOAD. The reload clears irq_flag there, so the pulse
//           is exactly 1 cycle.
//   irq_flag in one-shot mode stays high until the next LOAD, i.e. software
//     re-sets EN, or until reset.
//   Timing: with PRESET = N >= 1, IRQ rises N+2 cycles after the edge where EN
//     is set (1 cycle LOAD, N-1 decrements, 1 cycle to INT, 1 cycle to flag).
//     PRESET = 0 behaves as PRESET = 1.
//   Simultaneous events:
//     - A CPU write to CTRL in the same cycle as INT clearing EN: the CPU
//       write wins for every CTRL bit.
//     - A PRESET write during CNT does not affect COUNT until the next LOAD.
//     - Clearing EN mid-count freezes COUNT. Setting EN again restarts from
//       LOAD with the current PRESET; it does not resume.
//   Reset mid-operation: immediate return to reset values, no pending IRQ.
//   COUNT never wraps: it saturates at 0 and never decrements below 0.
// STRUCTURE
//   Shared package/header (constant.v):
//     - register offsets TC_CTRL=2'd0, TC_PRESET=2'd1, TC_COUNT=2'd2
//     - state encodings TC_IDLE/TC_LOAD/TC_CNT/TC_INT
//     - CTRL field positions TC_EN=0, TC_MODE=2:1, TC_IM=3
//     - TC0/TC1 base addresses
//   Single flat module; no sub-module is warranted. The register file and the
//     FSM live in two always blocks sharing one clock and one reset.
// TESTING
//   1. Reset:
//      - pulse reset_n low mid-count -> COUNT=0, IRQ=0, state IDLE in the
//        same cycle (asynchronous).
//      - read 0x7F00, 0x7F04 and 0x7F08 afterwards -> all return 0.
//   2. One-shot:
//      - PRESET=5, CTRL=0x9 (EN, IM, MODE0) -> COUNT reads 5,4,3,2,1,0.
//      - IRQ rises 7 cycles after the write and stays high.
//      - CTRL then reads 0x8 (EN cleared by hardware).
//   3. Auto-reload: PRESET=3, CTRL=0xB -> IRQ is a 1-cycle pulse every 5
//      cycles; COUNT sequence is 3,2,1,0,(INT),3,...
//   4. Mask: PRESET=2, CTRL=0x1 (IM=0) -> IRQ stays 0 throughout; COUNT
//      still reaches 0 and CTRL reads 0x0.
//   5. Disable/restart and ignored writes:
//      - clear EN when COUNT=10 -> COUNT frozen at 10.
//      - write COUNT=0x1234 -> ignored.
//      - set EN again -> COUNT reloads to PRESET.
//   6. Collision: CPU writes CTRL=0x9 on the INT cycle of a one-shot run ->
//      CTRL reads 0x9 and the FSM restarts from LOAD; Din upper bits are
//      masked to 0.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register offsets,
// CTRL field positions, FSM states and the bridge base addresses.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int unsigned TC_EN       = 0;
  localparam int unsigned TC_MODE_LSB = 1;
  localparam int unsigned TC_MODE_MSB = 2;
  localparam int unsigned TC_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

  typedef enum logic [1:0] {
    TcIdle,
    TcLoad,
    TcCnt,
    TcInt
  } tc_state_e;

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side bus of one timer: address/strobe/data in, read data and
// interrupt request out.
interface timer_counter_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, output WE, output Din, input Dout, input IRQ);
  modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with CTRL/PRESET/COUNT registers, one-shot or
// auto-reload operation and a maskable interrupt flag.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] CTRL_MASK  = 32'h0000_000F,
  parameter logic [31:0] RESET_CTRL = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  timer_counter_if.slave  bus
);

  tc_state_e   state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic [1:0] offset;
  logic       wr_ctrl, wr_preset;
  logic       unused_addr;

  assign offset      = bus.Addr[3:2];
  assign wr_ctrl     = bus.WE && (offset == TC_CTRL);
  assign wr_preset   = bus.WE && (offset == TC_PRESET);
  assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    // Hardware EN clear is applied first so a same-cycle CPU write wins.
    if (state_q == TcInt && ctrl_q[TC_MODE_MSB:TC_MODE_LSB] != MODE_RELOAD) begin
      ctrl_d[TC_EN] = 1'b0;
    end
    if (wr_ctrl)   ctrl_d   = bus.Din & CTRL_MASK;
    if (wr_preset) preset_d = bus.Din;

    // The FSM sees EN as it will be after this edge, so a write takes effect at once.
    case (state_q)
      TcIdle: begin
        if (ctrl_d[TC_EN]) state_d = TcLoad;
      end
      TcLoad: begin
        count_d = preset_q;
        flag_d  = 1'b0;
        state_d = TcCnt;
      end
      TcCnt: begin
        if (!ctrl_d[TC_EN]) begin
          state_d = TcIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = TcInt;
        end
      end
      TcInt: begin
        flag_d  = 1'b1;
        state_d = (ctrl_q[TC_MODE_MSB:TC_MODE_LSB] == MODE_RELOAD) ? TcLoad : TcIdle;
      end
      default: state_d = TcIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TcIdle;
      ctrl_q   <= RESET_CTRL & CTRL_MASK;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (offset)
      TC_CTRL:   bus.Dout = ctrl_q;
      TC_PRESET: bus.Dout = preset_q;
      TC_COUNT:  bus.Dout = count_q;
      default:   bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = ctrl_q[TC_IM] & flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with literal
// expectations plus a randomized run compared against a timeline model.
module tb_timer_counter;

  localparam logic [31:0] TC0 = 32'h0000_7F00;
  localparam logic [31:0] TC1 = 32'h0000_7F10;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  timer_counter_if bus ();

  timer_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: m_t counts edges since a run began (-1 = not running). The edge
  // after the start loads PRESET; COUNT then follows n-(t-1) arithmetically
  // until t = n+1, the terminal step that raises the flag on the next edge.
  logic [31:0] m_ctrl, m_preset, m_count;
  bit          m_flag;
  longint      m_t, m_n;

  function automatic void model_reset();
    m_ctrl = 32'd0; m_preset = 32'd0; m_count = 32'd0;
    m_flag = 1'b0;  m_t = -1;         m_n = 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return m_ctrl;
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_edge(input bit w, input logic [1:0] off, input logic [31:0] d);
    bit          wr_c = w && (off == 2'd0);
    bit          wr_p = w && (off == 2'd1);
    bit          en   = wr_c ? d[0] : m_ctrl[0];
    logic [31:0] ctrl_nx = m_ctrl;
    if (m_t < 0) begin
      if (en) m_t = 0;
    end else if (m_t == 0) begin
      m_count = m_preset;
      m_flag  = 1'b0;
      m_n     = (m_preset == 32'd0) ? 1 : longint'(m_preset);
      m_t     = 1;
    end else if (m_t <= m_n) begin
      if (!en) m_t = -1;
      else begin
        m_t++;
        m_count = (m_t <= m_n) ? 32'(m_n - m_t + 1) : 32'd0;
      end
    end else begin
      m_flag = 1'b1;
      if (m_ctrl[2:1] == 2'b01) m_t = 0;
      else begin
        m_t = -1;
        ctrl_nx[0] = 1'b0;
      end
    end
    if (wr_c) ctrl_nx = d & 32'h0000_000F;
    if (wr_p) m_preset = d;
    m_ctrl = ctrl_nx;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against model before the edge, advance model.
  task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.WE = w; bus.Addr = a; bus.Din = d;
    #1;
    check_eq("model_dout", bus.Dout, model_read(a));
    check_eq("model_irq", {31'd0, bus.IRQ}, {31'd0, m_ctrl[3] & m_flag});
    @(posedge clk);
    model_edge(w, a[3:2], d);
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.WE = 1'b0; bus.Addr = a;
    #1;
    check_eq(tag, bus.Dout, exp);
  endtask

  task automatic stop_timer();
    step(1'b1, TC0, 32'd0);
    repeat (3) step(1'b0, TC0, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, base;
    logic [1:0]  off;
    bit          w;
    int          m;

    reset_n = 1'b0; bus.WE = 1'b0; bus.Addr = TC0; bus.Din = 32'd0;
    model_reset();
    #1;
    peek("rst_ctrl", TC0, 32'd0);
    peek("rst_preset", TC0 + 4, 32'd0);
    check_eq("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, TC0 + 8, 32'd0);

    // One-shot, PRESET=5
    step(1'b1, TC0 + 4, 32'd5);
    step(1'b1, TC0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, TC0 + 8, 32'd0);
      peek("oneshot_count", TC0 + 8, (k <= 6) ? 32'(6 - k) : 32'd0);
      check_eq("oneshot_irq", {31'd0, bus.IRQ}, (k >= 7) ? 32'd1 : 32'd0);
    end
    peek("oneshot_ctrl", TC0, 32'h8);

    // Auto-reload, PRESET=3: pulse every 5 cycles
    step(1'b1, TC0 + 4, 32'd3);
    step(1'b1, TC1, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, TC0 + 8, 32'd0);
      m = k % 5;
      peek("reload_count", TC0 + 8, (m == 0 || m == 4) ? 32'd0 : 32'(4 - m));
      check_eq("reload_irq", {31'd0, bus.IRQ}, (m == 0) ? 32'd1 : 32'd0);
    end
    stop_timer();

    // Masked interrupt
    step(1'b1, TC0 + 4, 32'd2);
    step(1'b1, TC0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, TC0 + 8, 32'd0);
      check_eq("mask_irq", {31'd0, bus.IRQ}, 32'd0);
    end
    peek("mask_count", TC0 + 8, 32'd0);
    peek("mask_ctrl", TC0, 32'd0);

    // Disable mid-count, ignored writes, restart from PRESET
    step(1'b1, TC0 + 4, 32'd20);
    step(1'b1, TC0, 32'h1);
    repeat (11) step(1'b0, TC0 + 8, 32'd0);
    peek("run_count10", TC0 + 8, 32'd10);
    step(1'b1, TC0, 32'd0);
    repeat (3) step(1'b0, TC0 + 8, 32'd0);
    peek("frozen_count", TC0 + 8, 32'd10);
    step(1'b1, TC0 + 8, 32'h1234);
    step(1'b1, TC0 + 12, 32'hFFFF_FFFF);
    peek("count_ro", TC0 + 8, 32'd10);
    peek("off_c_zero", TC0 + 12, 32'd0);
    step(1'b1, TC0 + 4, 32'd7);
    step(1'b1, TC0, 32'h1);
    step(1'b0, TC0 + 8, 32'd0);
    peek("restart_count", TC0 + 8, 32'd7);
    stop_timer();

    // CPU CTRL write on the INT cycle of a one-shot run
    step(1'b1, TC0 + 4, 32'd2);
    step(1'b1, TC0, 32'h9);
    repeat (3) step(1'b0, TC0 + 8, 32'd0);
    peek("coll_int_count", TC0 + 8, 32'd0);
    step(1'b1, TC0, 32'hFFFF_FFF9);
    peek("coll_ctrl", TC0, 32'h9);
    check_eq("coll_irq_set", {31'd0, bus.IRQ}, 32'd1);
    step(1'b0, TC0 + 8, 32'd0);
    step(1'b0, TC0 + 8, 32'd0);
    peek("coll_reload", TC0 + 8, 32'd2);
    check_eq("coll_irq_clr", {31'd0, bus.IRQ}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      w    = ($urandom_range(0, 15) < 3);
      off  = 2'($urandom_range(0, 3));
      base = ($urandom_range(0, 1) == 1) ? TC1 : TC0;
      a    = base | {28'd0, off, 2'b00};
      d    = (off == 2'd1) ? 32'($urandom_range(0, 9)) : $urandom;
      step(w, a, d);
    end

    // Asynchronous reset mid-count
    stop_timer();
    step(1'b1, TC0 + 4, 32'd50);
    step(1'b1, TC0, 32'h9);
    repeat (10) step(1'b0, TC0 + 8, 32'd0);
    peek("pre_rst_count", TC0 + 8, 32'd41);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst_irq", {31'd0, bus.IRQ}, 32'd0);
    peek("arst_count", TC0 + 8, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    peek("post_rst_ctrl", TC0, 32'd0);
    peek("post_rst_preset", TC0 + 4, 32'd0);
    peek("post_rst_count", TC0 + 8, 32'd0);
    repeat (4) step(1'b0, TC0 + 8, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
